// File: rtl/dot_product_feeder.sv
// dot_product_feeder: streams two operand vectors from a dual-read-port memory into a mac unit
// and returns the 65-bit dot product over a valid/ready handshake.
//
// Ports:
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   start, base_a, base_b, len command; operands latched when accepted in IDLE
//   busy                      high whenever a command is in progress
//   rd_en, rd_addr_a/b        registered memory read strobe and addresses
//   rd_data_a/b               memory read data, valid one cycle after rd_en
//   mac_clear, mac_next       registered controls to the mac
//   mac_a, mac_b              mac operands, zero unless read data is valid
//   mac_psum                  mac accumulator output
//   result, result_valid      dot product, held while valid
//   result_ready              consumer accepts result
module dot_product_feeder #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [31:0]       rd_data_a,
    input  logic [31:0]       rd_data_b,
    output logic              mac_clear,
    output logic              mac_next,
    output logic [31:0]       mac_a,
    output logic [31:0]       mac_b,
    input  logic [64:0]       mac_psum,
    output logic [64:0]       result,
    output logic              result_valid,
    input  logic              result_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [2:0]        vld;
    logic              accept, last_issue, drain_done;

    assign accept     = (state == IDLE) && start;
    assign last_issue = (state == ISSUE) && (remaining == LEN_W'(1));
    // vld[2] covers the final accumulate cycle; once it has emptied, psum has settled
    assign drain_done = (state == DRAIN) && (vld == 3'b000);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len != '0) ? ISSUE : RESULT;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = RESULT;
            RESULT:  if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = state != IDLE;
        result_valid = state == RESULT;
        mac_next     = vld[2];
        mac_a        = vld[0] ? rd_data_a : '0;
        mac_b        = vld[0] ? rd_data_b : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            remaining <= '0;
            mac_clear <= 1'b0;
            vld       <= '0;
            result    <= '0;
        end else begin
            mac_clear <= accept && (len != '0);
            vld       <= {vld[1:0], rd_en};
            if (accept) begin
                rd_en     <= len != '0;
                rd_addr_a <= base_a;
                rd_addr_b <= base_b;
                remaining <= len;
            end else if (state == ISSUE) begin
                remaining <= remaining - LEN_W'(1);
                if (last_issue) begin
                    rd_en <= 1'b0;
                end else begin
                    rd_addr_a <= rd_addr_a + ADDR_W'(1);
                    rd_addr_b <= rd_addr_b + ADDR_W'(1);
                end
            end
            if (accept && (len == '0)) result <= '0;
            else if (drain_done)       result <= mac_psum;
        end
    end
endmodule

// File: tb/tb_dot_product_feeder.sv
// tb_dot_product_feeder: randomized and directed checks of dot_product_feeder against a memory, a mac model and a dot-product reference.
module tb_dot_product_feeder;
    logic        clk = 0, reset_n = 1, start = 0, result_ready = 0;
    logic [9:0]  base_a = 0, base_b = 0;
    logic [10:0] len = 0;
    logic        busy, rd_en, mac_clear, mac_next, result_valid;
    logic [9:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b, mac_a, mac_b;
    logic [64:0] mac_psum, result;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] ma_r, mb_r;
    logic [63:0] prod_r;
    logic [64:0] acc;
    int n_cmp = 0, n_err = 0;
    int rd_q[$], nx_q[$], clr_q[$];
    logic [9:0] addr_q[$];
    int valid_cyc;
    bit both;
    logic [64:0] res;

    always #5 clk = ~clk;

    dot_product_feeder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_a(base_a), .base_b(base_b), .len(len),
        .busy(busy), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .mac_clear(mac_clear), .mac_next(mac_next),
        .mac_a(mac_a), .mac_b(mac_b), .mac_psum(mac_psum), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always @(posedge clk) if (rd_en) begin
        rd_data_a <= mem_a[rd_addr_a];
        rd_data_b <= mem_b[rd_addr_b];
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma_r <= 0; mb_r <= 0; prod_r <= 0; acc <= 0;
        end else begin
            ma_r   <= mac_a;
            mb_r   <= mac_b;
            prod_r <= 64'(ma_r) * 64'(mb_r);
            if (mac_clear)     acc <= 0;
            else if (mac_next) acc <= acc + {1'b0, prod_r};
        end
    end
    assign mac_psum = acc;

    function automatic logic [64:0] model(logic [9:0] ba, logic [9:0] bb, int n);
        logic [64:0] s = 0;
        for (int i = 0; i < n; i++) s += 65'(64'(mem_a[ba + 10'(i)]) * 64'(mem_b[bb + 10'(i)]));
        return s;
    endfunction

    function automatic bit seq_ok(int q[$], int first, int n);
        if (q.size() != n) return 0;
        for (int i = 0; i < n; i++) if (q[i] != first + i) return 0;
        return 1;
    endfunction

    task automatic run_cmd(input logic [9:0] ba, input logic [9:0] bb, input int n);
        rd_q.delete(); nx_q.delete(); clr_q.delete(); addr_q.delete();
        valid_cyc = -1; both = 0; res = 'x;
        @(negedge clk);
        start = 1; base_a = ba; base_b = bb; len = 11'(n);
        @(posedge clk); #1;
        start = 0;
        for (int k = 1; k <= n + 20; k++) begin
            if (rd_en) begin rd_q.push_back(k); addr_q.push_back(rd_addr_a); end
            if (mac_next) nx_q.push_back(k);
            if (mac_clear) clr_q.push_back(k);
            if (mac_clear && mac_next) both = 1;
            if (result_valid) begin valid_cyc = k; res = result; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (valid_cyc < 0) begin n_err++; $display("FAIL timeout: result_valid never rose for len=%0d", n); end
    endtask

    task automatic do_accept();
        result_ready = 1;
        @(posedge clk); #1;
        result_ready = 0;
    endtask

    task automatic test_reset();
        #2 reset_n = 0;
        #10;
        n_cmp++;
        if ({busy, rd_en, mac_clear, mac_next, result_valid} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, rd_en, mac_clear, mac_next, result_valid});
        end
        n_cmp++;
        if ({result, rd_addr_a, rd_addr_b, mac_a, mac_b} !== '0) begin
            n_err++; $display("FAIL reset_data: result=%h addr_a=%h addr_b=%h", result, rd_addr_a, rd_addr_b);
        end
        @(negedge clk) reset_n = 1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin mem_a[100 + i] = 32'(i + 1); mem_b[200 + i] = 32'(i + 5); end
        run_cmd(10'd100, 10'd200, 4);
        n_cmp++; if (res !== 65'd70) begin n_err++; $display("FAIL basic_result: got %0d want 70", res); end
        n_cmp++; if (valid_cyc !== 9) begin n_err++; $display("FAIL basic_valid_cycle: got %0d want 9", valid_cyc); end
        n_cmp++; if (!seq_ok(rd_q, 1, 4)) begin n_err++; $display("FAIL basic_rd_en: got %p want cycles 1..4", rd_q); end
        n_cmp++; if (!seq_ok(nx_q, 4, 4)) begin n_err++; $display("FAIL basic_mac_next: got %p want cycles 4..7", nx_q); end
        n_cmp++; if (!seq_ok(clr_q, 1, 1) || both) begin n_err++; $display("FAIL basic_mac_clear: got %p overlap=%0d want cycle 1 only", clr_q, both); end
        do_accept();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_overflow();
        mem_a[300] = '1; mem_a[301] = '1; mem_b[310] = '1; mem_b[311] = '1;
        run_cmd(10'd300, 10'd310, 2);
        n_cmp++;
        if (res !== 65'h1_FFFF_FFFC_0000_0002) begin n_err++; $display("FAIL overflow_result: got %h want 1fffffffc00000002", res); end
        do_accept();
    endtask

    task automatic test_len0();
        run_cmd(10'd5, 10'd6, 0);
        n_cmp++; if (res !== 65'd0 || valid_cyc !== 1) begin n_err++; $display("FAIL len0: result=%0d valid_cycle=%0d want 0 and 1", res, valid_cyc); end
        n_cmp++; if (rd_q.size() != 0 || clr_q.size() != 0) begin n_err++; $display("FAIL len0_strobes: rd_en=%0d clear=%0d want 0 and 0", rd_q.size(), clr_q.size()); end
        do_accept();
    endtask

    task automatic test_back_to_back();
        logic [64:0] exp = model(10'd400, 10'd410, 3);
        run_cmd(10'd400, 10'd410, 3);
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL hold_result: got %h want %h", res, exp); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1; len = 11'($urandom_range(1, 5));
            @(posedge clk); #1;
            n_cmp++;
            if (result !== exp || result_valid !== 1'b1 || rd_en !== 1'b0) begin
                n_err++; $display("FAIL hold_stable: result=%h valid=%b rd_en=%b want %h 1 0", result, result_valid, rd_en, exp);
            end
        end
        @(negedge clk);
        result_ready = 1;
        @(posedge clk); #1;
        start = 0; result_ready = 0;
        n_cmp++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_err++; $display("FAIL handshake_idle: busy=%b valid=%b want 0 0", busy, result_valid); end
        mem_a[500] = 3; mem_b[500] = 3;
        run_cmd(10'd500, 10'd500, 1);
        n_cmp++; if (res !== 65'd9 || valid_cyc !== 6) begin n_err++; $display("FAIL back_to_back: result=%0d cycle=%0d want 9 and 6", res, valid_cyc); end
        do_accept();
    endtask

    task automatic test_wrap();
        logic [9:0] exp_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [64:0] exp = model(10'h3FE, 10'h020, 4);
        run_cmd(10'h3FE, 10'h020, 4);
        n_cmp++;
        if (addr_q.size() != 4 || addr_q[0] !== exp_addr[0] || addr_q[1] !== exp_addr[1] || addr_q[2] !== exp_addr[2] || addr_q[3] !== exp_addr[3]) begin
            n_err++; $display("FAIL wrap_addr: got %p want 3fe 3ff 000 001", addr_q);
        end
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL wrap_result: got %h want %h", res, exp); end
        do_accept();
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [9:0] ba = 10'($urandom), bb = 10'($urandom);
            int n = $urandom_range(1, 24);
            logic [64:0] exp = model(ba, bb, n);
            run_cmd(ba, bb, n);
            n_cmp++;
            if (res !== exp || valid_cyc !== n + 5 || !seq_ok(nx_q, 4, n)) begin
                n_err++; $display("FAIL random_%0d: len=%0d result=%h want %h cycle=%0d want %0d", t, n, res, exp, valid_cyc, n + 5);
            end
            do_accept();
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1; base_a = 10'd50; base_b = 10'd60; len = 11'd8;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL midreset_issue: rd_en=%b want 1", rd_en); end
        reset_n = 0;
        #1;
        n_cmp++;
        if ({busy, rd_en, mac_clear, mac_next, result_valid} !== 5'b0 || {result, rd_addr_a, rd_addr_b, mac_a, mac_b} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: ctrl=%b addr_a=%h result=%h want all 0", {busy, rd_en, mac_clear, mac_next, result_valid}, rd_addr_a, result);
        end
        @(negedge clk) reset_n = 1;
        for (int i = 0; i < 4; i++) begin mem_a[600 + i] = 1; mem_b[700 + i] = 2; end
        run_cmd(10'd600, 10'd700, 4);
        n_cmp++; if (res !== 65'd8) begin n_err++; $display("FAIL midreset_result: got %0d want 8", res); end
        do_accept();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin mem_a[i] = $urandom; mem_b[i] = $urandom; end
        test_reset();
        test_basic();
        test_overflow();
        test_len0();
        test_back_to_back();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dot_product_feeder.md
# dot_product_feeder

Sequencing controller that drives the `mac` multiply-accumulate unit from the other side of its `clear`/`next`/`a`/`b` interface. On a `start` command it streams two length-`len` operand vectors from a dual-read-port memory into the MAC. It aligns `next` to the MAC's two-stage operand/product pipeline, waits for the final accumulation, and returns the 65-bit dot product over a valid/ready result handshake. It sits between the memory subsystem and one `mac` instance, and one command is processed at a time.

## Interface
- ADDR_W, 10, memory word-address width
- LEN_W, 11, vector length width (0 .. 2^LEN_W-1 elements)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- start  input  1  command pulse; accepted only in IDLE
- base_a  input  ADDR_W  start address of vector A; latched on accept
- base_b  input  ADDR_W  start address of vector B; latched on accept
- len  input  LEN_W  element count; latched on accept
- busy  output  1  high whenever state != IDLE
- rd_en  output  1  memory read strobe (registered)
- rd_addr_a  output  ADDR_W  read address, port A (registered)
- rd_addr_b  output  ADDR_W  read address, port B (registered)
- rd_data_a  input  32  port A data; valid exactly 1 cycle after the rd_en cycle
- rd_data_b  input  32  port B data; same timing as port A
- mac_clear  output  1  to mac.clear (registered)
- mac_next  output  1  to mac.next (registered)
- mac_a  output  32  to mac.a; rd_data_a while read data is valid, else 0
- mac_b  output  32  to mac.b; rd_data_b while read data is valid, else 0
- mac_psum  input  65  from mac.psum
- result  output  65  dot product; stable while result_valid is high
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result

## Operation
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE with start=1 and len!=0:
  - latch base_a, base_b, len
  - go to ISSUE
- IDLE with start=1 and len=0:
  - result <= 0
  - go to RESULT
  - no rd_en, no mac_clear
- ISSUE:
  - rd_en=1 for exactly len consecutive cycles; addresses begin at the latched bases and increment by 1 per cycle
  - address arithmetic is modulo 2^ADDR_W (wrap from all-ones to 0)
  - mac_clear=1 in the first ISSUE cycle only
- Valid tracking: 3-stage shift of rd_en.
  - stage 1 (data-valid) gates mac_a/mac_b to rd_data
  - stage 3 drives mac_next
  - MAC path: a_reg at +2, mult_reg at +3, accumulate during +3
- DRAIN:
  - entered after the last rd_en cycle
  - lasts until the shift register is empty, plus one cycle for mac_psum to settle
  - on the final DRAIN edge: result <= mac_psum, then go to RESULT
- RESULT:
  - result_valid=1; result held constant
  - on a cycle with result_valid & result_ready, return to IDLE next cycle
- start is ignored in any state other than IDLE, including the RESULT handshake cycle.
- Arithmetic: no saturation; result is the 65-bit mac_psum verbatim.
- mac_clear and mac_next are never high in the same cycle.
- Async reset (also possible mid-operation):
  - state returns to IDLE
  - all outputs, address registers, shift register and result go to 0
  - the MAC shares reset_n, so no stale accumulation survives

## Timing
- Cycle 0 is the accept cycle (start high in IDLE).
- len=N>0:
  - rd_en and busy high from cycle 1; rd_en for cycles 1..N
  - mac_clear in cycle 1
  - mac_a/mac_b valid in cycles 2..N+1
  - mac_next in cycles 4..N+3
  - result captured at the end of cycle N+4
  - result_valid high from cycle N+5
- len=0: result_valid high from cycle 1.
- Throughput: one element per cycle; a new start is accepted no earlier than the cycle after the handshake.
- Reset values: every output is 0, including busy, rd_en, mac_clear, mac_next, result_valid and result.

## Test plan
- len=4, A=[1,2,3,4], B=[5,6,7,8] -> result=70, result_valid at cycle 9, rd_en high exactly cycles 1-4, mac_next exactly cycles 4-7, mac_clear cycle 1 only.
- len=2, all operands 0xFFFFFFFF -> result=0x1_FFFF_FFFC_0000_0002 (bit 64 set).
- len=0 -> result=0 with result_valid in cycle 1; no rd_en or mac_clear ever asserted.
- Hold result_ready=0 for 10 cycles while pulsing start -> result stable and start ignored. Then assert ready -> IDLE. Then run a back-to-back command with A=[3], B=[3] -> result=9, proving the clear took effect.
- base_a=2^ADDR_W-2, len=4 -> rd_addr_a sequence 0x3FE, 0x3FF, 0x000, 0x001 (ADDR_W=10).
- Assert reset_n low in the middle of ISSUE of a len=8 command -> all outputs 0 immediately. After release, a len=4 command ([1,1,1,1]·[2,2,2,2]) -> result=8.
